// File: rtl/fib_controller_if.sv
// Control/handshake bundle between the requester, the Fibonacci datapath and fib_controller.
// cycle_count exists only when FIB_CTRL_CYCLE_COUNT_EN is defined.
interface fib_controller_if #(
    parameter int NWIDTH   = 5,
    parameter int CYCWIDTH = 8
);
    // Handshake: the requester raises start with N and holds both until done=1,
    // then drops start; a new request needs start=0 for at least one cycle.
    logic              start;
    logic [NWIDTH-1:0] N;
    logic              zero;
    logic              load_regs;
    logic              add_regs;
    logic              shift_regs;
    logic              decr_c;
    logic              busy;
    logic              done;
    logic [2:0]        state_dbg;
`ifdef FIB_CTRL_CYCLE_COUNT_EN
    logic [CYCWIDTH-1:0] cycle_count;

    modport master (
        output start, N, zero,
        input  load_regs, add_regs, shift_regs, decr_c, busy, done, state_dbg, cycle_count
    );

    modport slave (
        input  start, N, zero,
        output load_regs, add_regs, shift_regs, decr_c, busy, done, state_dbg, cycle_count
    );
`else
    modport master (
        output start, N, zero,
        input  load_regs, add_regs, shift_regs, decr_c, busy, done, state_dbg
    );

    modport slave (
        input  start, N, zero,
        output load_regs, add_regs, shift_regs, decr_c, busy, done, state_dbg
    );
`endif
endinterface

// File: rtl/fib_controller.sv
// Moore FSM sequencing the Fibonacci datapath (load, then TEST/ADD/SHIFT until zero).
// Optional busy-cycle counter enabled by FIB_CTRL_CYCLE_COUNT_EN.
module fib_controller #(
    parameter int NWIDTH   = 5,
    parameter int CYCWIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    fib_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic load_regs_c;
    logic add_regs_c;
    logic shift_regs_c;
    logic decr_c_c;
    logic busy_c;
    logic done_c;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs depend only on the registered state; inputs only steer state_next.
    always_comb begin
        state_next   = state;
        load_regs_c  = 1'b0;
        add_regs_c   = 1'b0;
        shift_regs_c = 1'b0;
        decr_c_c     = 1'b0;
        busy_c       = 1'b0;
        done_c       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.N < NWIDTH'(2)) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                load_regs_c = 1'b1;
                busy_c      = 1'b1;
                state_next  = S_TEST;
            end
            S_TEST: begin
                busy_c = 1'b1;
                if (bus.zero) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_ADD;
                end
            end
            S_ADD: begin
                add_regs_c = 1'b1;
                busy_c     = 1'b1;
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                shift_regs_c = 1'b1;
                decr_c_c     = 1'b1;
                busy_c       = 1'b1;
                state_next   = S_TEST;
            end
            S_DONE: begin
                done_c = 1'b1;
                if (!bus.start) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.load_regs  = load_regs_c;
    assign bus.add_regs   = add_regs_c;
    assign bus.shift_regs = shift_regs_c;
    assign bus.decr_c     = decr_c_c;
    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.state_dbg  = state;

`ifdef FIB_CTRL_CYCLE_COUNT_EN
    logic [CYCWIDTH-1:0] cycle_count_q;

    // The start edge itself is counted so the value seen in DONE equals the
    // start-to-done latency; a direct IDLE->DONE request leaves it at 0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cycle_count_q <= '0;
        end else if (state == S_IDLE && state_next != S_IDLE) begin
            cycle_count_q <= (state_next == S_LOAD) ? CYCWIDTH'(1) : '0;
        end else if (busy_c && cycle_count_q != {CYCWIDTH{1'b1}}) begin
            cycle_count_q <= cycle_count_q + CYCWIDTH'(1);
        end
    end

    assign bus.cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_fib_controller.sv
// Directed bench for fib_controller: bench-side datapath, per-cycle output sequence model,
// latency/result checks against both hand values and a Fibonacci model.
module tb_fib_controller;

    localparam int NW = 5;

    // {load_regs, add_regs, shift_regs, decr_c, busy, done}
    localparam logic [5:0] V_IDLE  = 6'b000000;
    localparam logic [5:0] V_LOAD  = 6'b100010;
    localparam logic [5:0] V_TEST  = 6'b000010;
    localparam logic [5:0] V_ADD   = 6'b010010;
    localparam logic [5:0] V_SHIFT = 6'b001110;
    localparam logic [5:0] V_DONE  = 6'b000001;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    fib_controller_if #(.NWIDTH(NW), .CYCWIDTH(8)) bus ();

    fib_controller #(.NWIDTH(NW), .CYCWIDTH(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int fails  = 0;
    logic [5:0] exp_q[$];

    // Datapath attached to the controller's strobes
    logic [15:0]   n1, n2, temp;
    logic [NW-1:0] cnt;
    logic [15:0]   dpresult;

    always @(posedge clock) begin
        if (!reset_n) begin
            n1 <= 16'd1; n2 <= 16'd1; temp <= 16'd0; cnt <= '0;
        end else begin
            if (bus.load_regs) begin
                n1 <= 16'd1; n2 <= 16'd1; temp <= 16'd0; cnt <= bus.N - NW'(2);
            end
            if (bus.add_regs) temp <= n1 + n2;
            if (bus.shift_regs) begin
                n1 <= n2; n2 <= temp;
            end
            if (bus.decr_c) cnt <= cnt - NW'(1);
        end
    end

    assign bus.zero = (cnt == '0);
    assign dpresult = (bus.N < NW'(2)) ? 16'd1 : n2;

    function automatic logic [5:0] out_vec();
        return {bus.load_regs, bus.add_regs, bus.shift_regs, bus.decr_c, bus.busy, bus.done};
    endfunction

    function automatic int fib_model(input int n);
        int a = 1, b = 1, t;
        for (int i = 3; i <= n; i++) begin
            t = a + b; a = b; b = t;
        end
        return b;
    endfunction

    function automatic int lat_model(input int n);
        return (n < 2) ? 1 : 3 + 3 * (n - 2);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected output vector after each edge following the start sample
    task automatic push_seq(input int n);
        if (n < 2) begin
            exp_q.push_back(V_DONE);
        end else begin
            exp_q.push_back(V_LOAD);
            for (int i = 0; i < n - 2; i++) begin
                exp_q.push_back(V_TEST);
                exp_q.push_back(V_ADD);
                exp_q.push_back(V_SHIFT);
            end
            exp_q.push_back(V_TEST);
            exp_q.push_back(V_DONE);
        end
    endtask

    // Compare process: strobe exclusivity every cycle, sequence while a run is tracked
    always @(negedge clock) begin
        logic [5:0] act;
        logic [5:0] e;
        act = out_vec();
        check("strobe_onehot", (32'(act[5]) + 32'(act[4]) + 32'(act[3]) <= 1) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_seq", int'(act), int'(e));
        end
    end

    // Called at negedge+#1 with the DUT in IDLE; leaves it back in IDLE
    task automatic run(input int n, input int exp_res, input int exp_lat, input bit hold);
        int cyc = 0;
        bus.N = NW'(n);
        bus.start = 1'b1;
        push_seq(n);
        while (!bus.done && cyc < 200) begin
            @(negedge clock); #1;
            cyc++;
        end
        check("done_seen", int'(bus.done), 1);
        check("latency", cyc, exp_lat);
        check("latency_model", cyc, lat_model(n));
        check("dpresult", int'(dpresult), exp_res);
        check("dpresult_model", int'(dpresult), fib_model(n));
        if (hold) begin
            repeat (3) begin
                @(negedge clock); #1;
            end
            check("done_held", int'(out_vec()), int'(V_DONE));
            check("dpresult_held", int'(dpresult), exp_res);
        end
        bus.start = 1'b0;
        @(negedge clock); #1;
        check("idle_after_drop", int'(out_vec()), int'(V_IDLE));
        check("idle_state", int'(bus.state_dbg), 0);
    endtask

    initial begin
        int cyc;
        int adds;
        bus.start = 1'b1;
        bus.N = NW'(5);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        check("reset_outputs", int'(out_vec()), int'(V_IDLE));
        check("reset_state", int'(bus.state_dbg), 0);
        bus.start = 1'b0;
        reset_n = 1'b1;
        @(negedge clock); #1;

        run(5, 5, 12, 1'b0);
`ifdef FIB_CTRL_CYCLE_COUNT_EN
        check("cycle_count", int'(bus.cycle_count), 12);
`endif
        run(2, 1, 3, 1'b0);
        run(0, 1, 1, 1'b0);
        run(1, 1, 1, 1'b0);
        run(10, 55, 27, 1'b1);
        run(3, 2, 6, 1'b0);

        // Reset in the 4th ADD of an N=20 run
        bus.N = NW'(20);
        bus.start = 1'b1;
        push_seq(20);
        cyc = 0;
        adds = 0;
        while (adds < 4 && cyc < 200) begin
            @(negedge clock); #1;
            cyc++;
            if (bus.add_regs) adds++;
        end
        check("fourth_add_seen", adds, 4);
        reset_n = 1'b0;
        bus.start = 1'b0;
        exp_q.delete();
        @(negedge clock); #1;
        check("reset_mid_outputs", int'(out_vec()), int'(V_IDLE));
        check("reset_mid_state", int'(bus.state_dbg), 0);
        reset_n = 1'b1;
        @(negedge clock); #1;

        run(20, 6765, 57, 1'b0);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
